canv_vram_arb: RTL and testbench
================================

Name: canv_vram_arb

Overview:
Arbiter for the single canvas VRAM port in the pixel clock domain. It shares the port between three requesters:
- display read path: address from the canvas display AGU; absolute priority, never stalled, fixed latency.
- CPU (m0) and drawing engine (m1): read/write requesters with req/ack handshakes, round-robin between them in free cycles.

Returned read data is routed back to the requester that issued it, using a tag pipeline matched to VRAM latency.

Parameters:
WORD, 32, machine word / VRAM data width (bits)
ADDRW, 14, VRAM address width (bits)
VRAM_LAT, 1, VRAM read latency from registered address to vram_dout valid (cycles, >=1)
CNTW, 16, width of blocked-cycle statistics counters (bits)

Ports:
clk_pix  input  1  pixel clock
rst_pix  input  1  synchronous active-high reset in pixel clock domain
frame_start  input  1  frame start flag; clears statistics
disp_read  input  1  display read request this cycle (AGU vram read area)
disp_addr  input  ADDRW  display read address
disp_data  output  WORD  display read data
disp_valid  output  1  disp_data valid
m0_req, m1_req  input  1 each  requester wants access; held stable until ack
m0_we, m1_we  input  WORD/8 each  byte write enables; all zero = read
m0_addr, m1_addr  input  ADDRW each  address
m0_wdata, m1_wdata  input  WORD each  write data
m0_ack, m1_ack  output  1 each  request accepted this cycle (combinational)
m0_rdata, m1_rdata  output  WORD each  read data
m0_rvalid, m1_rvalid  output  1 each  read data valid, single cycle
vram_addr  output  ADDRW  VRAM address (registered)
vram_we  output  WORD/8  VRAM byte write enables (registered)
vram_din  output  WORD  VRAM write data (registered)
vram_dout  input  WORD  VRAM read data
m0_blk_cnt, m1_blk_cnt  output  CNTW each  saturating count of cycles requester was refused

Behaviour:
- Grant is decided combinationally each cycle:
  - disp_read=1: display wins; m0_ack=m1_ack=0.
  - else one requester with req: grant it.
  - else both req: grant the one not granted last (rr pointer).
  - rr pointer updates only on an m0/m1 grant. After reset, m0 has priority.
- mN_ack = mN_req && granted. A requester sees ack=1 for exactly the cycle its request is taken. If it holds req, it may be granted again next cycle.
- Cycle after grant:
  - vram_addr/vram_we/vram_din carry the granted access.
  - Display grant: vram_we=0.
  - No grant: vram_we=0; vram_addr holds its previous value.
- Read latency is 1+VRAM_LAT cycles from grant to data valid.
  - Display: disp_valid=1 and disp_data=vram_dout exactly 1+VRAM_LAT cycles after disp_read sampled high.
  - Masters: mN_rvalid=1 and mN_rdata=vram_dout 1+VRAM_LAT cycles after an ack with mN_we=0.
- Writes (any we bit set): no rvalid. Write becomes visible to a read granted in any later cycle.
- Tag pipeline is a VRAM_LAT+1 deep shift register of {valid, source in {disp,m0,m1}}. Exactly one of disp_valid/m0_rvalid/m1_rvalid is high per cycle, or none.
- Data outputs (disp_data, mN_rdata) may be driven from vram_dout unconditionally; only the valid flags are meaningful.
- mN_blk_cnt:
  - increments (saturating at all ones) each cycle mN_req=1 and mN_ack=0.
  - cleared on frame_start or rst_pix; frame_start has priority over increment in the same cycle.
- Reset values: all acks/valids 0, vram_we 0, vram_addr 0, vram_din 0, counters 0, rr pointer = last granted m1, tag pipeline all invalid.
- Reset mid-operation: in-flight reads are dropped; no rvalid/disp_valid for them after rst_pix deasserts.
- No combinational path from vram_dout to any ack.
- Continuous disp_read starves m0/m1 indefinitely by design; this is visible in blk_cnt.

Test Plan:
- Display stream: disp_read=1 for 8 cycles, addrs 0x10..0x17, VRAM_LAT=1, no masters -> disp_valid high 8 cycles starting 2 cycles later, data = contents of 0x10..0x17 in order, vram_we=0 throughout.
- Contention: m0 and m1 both read continuously with disp_read=0 -> acks alternate m0,m1,m0,m1; each rvalid 2 cycles after its ack with correct data; rvalids never overlap.
- Display priority: m0 requests read 0x20 while disp_read=1 for 5 cycles -> m0_ack=0 for those 5 cycles, m0_blk_cnt=5, ack on 6th cycle, m0_rvalid 2 cycles later; frame_start then clears m0_blk_cnt to 0.
- Byte write: m1 writes 0xAABBCCDD to 0x30 with we=4'b0011, then m0 reads 0x30 -> m1_ack then m0_ack, no m1_rvalid, m0_rdata low half=0xCCDD, upper bytes unchanged.
- Reset mid-read: m0 read acked, rst_pix pulsed the next cycle -> no m0_rvalid ever; all outputs at reset values; after release m0 wins a simultaneous m0/m1 request.
- Saturation: CNTW=4, m1 held off 20 cycles by disp_read -> m1_blk_cnt stops at 15.

Source files
------------

// File: rtl/canv_vram_arb.sv
// rtl/canv_vram_arb.sv - canvas VRAM port arbiter: display priority, m0/m1 round-robin, tagged read return
module canv_vram_arb #(
  parameter int WORD     = 32,
  parameter int ADDRW    = 14,
  parameter int VRAM_LAT = 1,
  parameter int CNTW     = 16
) (
  input  logic               clk_pix,
  input  logic               rst_pix,
  input  logic               frame_start,
  input  logic               disp_read,
  input  logic [ADDRW-1:0]   disp_addr,
  output logic [WORD-1:0]    disp_data,
  output logic               disp_valid,
  input  logic               m0_req,
  input  logic [WORD/8-1:0]  m0_we,
  input  logic [ADDRW-1:0]   m0_addr,
  input  logic [WORD-1:0]    m0_wdata,
  output logic               m0_ack,
  output logic [WORD-1:0]    m0_rdata,
  output logic               m0_rvalid,
  input  logic               m1_req,
  input  logic [WORD/8-1:0]  m1_we,
  input  logic [ADDRW-1:0]   m1_addr,
  input  logic [WORD-1:0]    m1_wdata,
  output logic               m1_ack,
  output logic [WORD-1:0]    m1_rdata,
  output logic               m1_rvalid,
  output logic [ADDRW-1:0]   vram_addr,
  output logic [WORD/8-1:0]  vram_we,
  output logic [WORD-1:0]    vram_din,
  input  logic [WORD-1:0]    vram_dout,
  output logic [CNTW-1:0]    m0_blk_cnt,
  output logic [CNTW-1:0]    m1_blk_cnt
);

  localparam int NBE = WORD / 8;
  localparam logic [1:0] SRC_DISP = 2'd0;
  localparam logic [1:0] SRC_M0   = 2'd1;
  localparam logic [1:0] SRC_M1   = 2'd2;
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  // Round-robin memory: 1 means m1 was the last master granted, so m0 is preferred next.
  logic r_last_m1;

  logic w_gd;
  logic w_g0;
  logic w_g1;
  logic w_tag_v;
  logic [1:0] w_tag_src;

  // Read tag shift register; stage k describes the access issued k+1 cycles ago.
  logic       r_tag_v   [0:VRAM_LAT];
  logic [1:0] r_tag_src [0:VRAM_LAT];

  logic [CNTW-1:0] r_blk0;
  logic [CNTW-1:0] r_blk1;

  logic [ADDRW-1:0] r_vram_addr;
  logic [NBE-1:0]   r_vram_we;
  logic [WORD-1:0]  r_vram_din;

  // Grant decision: display absolute, otherwise round-robin; nothing granted while in reset.
  always_comb begin
    w_gd = 1'b0;
    w_g0 = 1'b0;
    w_g1 = 1'b0;
    if (!rst_pix) begin
      if (disp_read) begin
        w_gd = 1'b1;
      end else if (m0_req && m1_req) begin
        w_g0 = r_last_m1;
        w_g1 = !r_last_m1;
      end else begin
        w_g0 = m0_req;
        w_g1 = m1_req;
      end
    end
  end

  // Only reads enter the return pipeline; writes are fire-and-forget.
  always_comb begin
    w_tag_v   = 1'b0;
    w_tag_src = SRC_DISP;
    if (w_gd) begin
      w_tag_v   = 1'b1;
      w_tag_src = SRC_DISP;
    end else if (w_g0) begin
      w_tag_v   = ~|m0_we;
      w_tag_src = SRC_M0;
    end else if (w_g1) begin
      w_tag_v   = ~|m1_we;
      w_tag_src = SRC_M1;
    end
  end

  // Round-robin pointer moves only when a master is actually granted.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_last_m1 <= 1'b1;
    end else if (w_g0) begin
      r_last_m1 <= 1'b0;
    end else if (w_g1) begin
      r_last_m1 <= 1'b1;
    end
  end

  // Register the granted access onto the VRAM port; idle cycles keep the address.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_vram_addr <= '0;
      r_vram_we   <= '0;
      r_vram_din  <= '0;
    end else if (w_gd) begin
      r_vram_addr <= disp_addr;
      r_vram_we   <= '0;
    end else if (w_g0) begin
      r_vram_addr <= m0_addr;
      r_vram_we   <= m0_we;
      r_vram_din  <= m0_wdata;
    end else if (w_g1) begin
      r_vram_addr <= m1_addr;
      r_vram_we   <= m1_we;
      r_vram_din  <= m1_wdata;
    end else begin
      r_vram_we   <= '0;
    end
  end

  // Shift read tags in step with VRAM latency; reset drops everything in flight.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      for (int i = 0; i <= VRAM_LAT; i++) begin
        r_tag_v[i]   <= 1'b0;
        r_tag_src[i] <= SRC_DISP;
      end
    end else begin
      r_tag_v[0]   <= w_tag_v;
      r_tag_src[0] <= w_tag_src;
      for (int i = 1; i <= VRAM_LAT; i++) begin
        r_tag_v[i]   <= r_tag_v[i-1];
        r_tag_src[i] <= r_tag_src[i-1];
      end
    end
  end

  // Saturating refusal counters; frame_start wins over counting.
  always_ff @(posedge clk_pix) begin
    if (rst_pix || frame_start) begin
      r_blk0 <= '0;
      r_blk1 <= '0;
    end else begin
      if (m0_req && !w_g0 && (r_blk0 != CNT_MAX)) begin
        r_blk0 <= r_blk0 + CNT_ONE;
      end
      if (m1_req && !w_g1 && (r_blk1 != CNT_MAX)) begin
        r_blk1 <= r_blk1 + CNT_ONE;
      end
    end
  end

  assign m0_ack     = w_g0;
  assign m1_ack     = w_g1;

  assign vram_addr  = r_vram_addr;
  assign vram_we    = r_vram_we;
  assign vram_din   = r_vram_din;

  assign disp_data  = vram_dout;
  assign m0_rdata   = vram_dout;
  assign m1_rdata   = vram_dout;

  assign disp_valid = r_tag_v[VRAM_LAT] && (r_tag_src[VRAM_LAT] == SRC_DISP);
  assign m0_rvalid  = r_tag_v[VRAM_LAT] && (r_tag_src[VRAM_LAT] == SRC_M0);
  assign m1_rvalid  = r_tag_v[VRAM_LAT] && (r_tag_src[VRAM_LAT] == SRC_M1);

  assign m0_blk_cnt = r_blk0;
  assign m1_blk_cnt = r_blk1;

endmodule

// File: tb/tb_canv_vram_arb.sv
// tb/tb_canv_vram_arb.sv - self-checking bench for canv_vram_arb with behavioural model
module tb_canv_vram_arb;

  localparam int WORD  = 32;
  localparam int ADDRW = 14;
  localparam int LAT   = 1;
  localparam int CNTW  = 4;
  localparam int CMAX  = (1 << CNTW) - 1;

  logic              clk_pix = 1'b0;
  logic              rst_pix;
  logic              frame_start;
  logic              disp_read;
  logic [ADDRW-1:0]  disp_addr;
  logic [WORD-1:0]   disp_data;
  logic              disp_valid;
  logic              m0_req, m1_req;
  logic [3:0]        m0_we, m1_we;
  logic [ADDRW-1:0]  m0_addr, m1_addr;
  logic [WORD-1:0]   m0_wdata, m1_wdata;
  logic              m0_ack, m1_ack;
  logic [WORD-1:0]   m0_rdata, m1_rdata;
  logic              m0_rvalid, m1_rvalid;
  logic [ADDRW-1:0]  vram_addr;
  logic [3:0]        vram_we;
  logic [WORD-1:0]   vram_din;
  logic [WORD-1:0]   vram_dout;
  logic [CNTW-1:0]   m0_blk_cnt, m1_blk_cnt;

  int total = 0;
  int bad   = 0;

  canv_vram_arb #(.WORD(WORD), .ADDRW(ADDRW), .VRAM_LAT(LAT), .CNTW(CNTW)) dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .frame_start(frame_start),
    .disp_read(disp_read), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_din(vram_din), .vram_dout(vram_dout),
    .m0_blk_cnt(m0_blk_cnt), .m1_blk_cnt(m1_blk_cnt)
  );

  always #5 clk_pix = ~clk_pix;

  function automatic logic [31:0] init_word(input int a);
    return 32'hA500_0000 | a;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // VRAM with one cycle read latency from registered address
  logic [31:0] vram_mem [0:16383];
  always @(posedge clk_pix) begin
    vram_dout <= vram_mem[vram_addr];
    if (vram_we != 4'b0) vram_mem[vram_addr] <= merge(vram_mem[vram_addr], vram_din, vram_we);
  end

  // Behavioural model state: memory image, due-cycle return slots, counters, rr preference
  logic [31:0] mem_m [0:16383];
  int          sl_src [8];
  logic [31:0] sl_dat [8];
  bit          m_last_m1 = 1'b1;
  int          m_blk0 = 0, m_blk1 = 0;
  logic [13:0] m_addr = '0;
  logic [3:0]  m_we = '0;
  logic [31:0] m_din = '0;
  int          cyc = 0;

  initial begin
    for (int a = 0; a < 16384; a++) begin
      vram_mem[a] = init_word(a);
      mem_m[a]    = init_word(a);
    end
    for (int s = 0; s < 8; s++) begin
      sl_src[s] = 0;
      sl_dat[s] = '0;
    end
  end

  // Compare process: every cycle, outputs vs. the model, then advance the model
  always @(negedge clk_pix) begin
    int slot, due, winner;
    slot = cyc % 8;
    due  = (cyc + 1 + LAT) % 8;
    if (rst_pix) begin
      chk("m0_ack_in_reset", m0_ack, 0);
      chk("m1_ack_in_reset", m1_ack, 0);
      for (int s = 0; s < 8; s++) sl_src[s] = 0;
      m_blk0 = 0; m_blk1 = 0; m_last_m1 = 1'b1;
      m_addr = '0; m_we = '0; m_din = '0;
    end else begin
      // winner: 0 none, 1 display, 2 m0, 3 m1
      winner = 0;
      if (disp_read) winner = 1;
      else if (m0_req && m1_req) winner = m_last_m1 ? 2 : 3;
      else if (m0_req) winner = 2;
      else if (m1_req) winner = 3;

      chk("m0_ack", m0_ack, winner == 2);
      chk("m1_ack", m1_ack, winner == 3);
      chk("disp_valid", disp_valid, sl_src[slot] == 1);
      chk("m0_rvalid", m0_rvalid, sl_src[slot] == 2);
      chk("m1_rvalid", m1_rvalid, sl_src[slot] == 3);
      if (sl_src[slot] == 1) chk("disp_data", disp_data, sl_dat[slot]);
      if (sl_src[slot] == 2) chk("m0_rdata", m0_rdata, sl_dat[slot]);
      if (sl_src[slot] == 3) chk("m1_rdata", m1_rdata, sl_dat[slot]);
      chk("vram_we", vram_we, m_we);
      chk("vram_addr", vram_addr, m_addr);
      if (m_we != 4'b0) chk("vram_din", vram_din, m_din);
      chk("m0_blk_cnt", m0_blk_cnt, m_blk0);
      chk("m1_blk_cnt", m1_blk_cnt, m_blk1);
      sl_src[slot] = 0;

      if (frame_start) begin
        m_blk0 = 0; m_blk1 = 0;
      end else begin
        if (m0_req && winner != 2 && m_blk0 < CMAX) m_blk0++;
        if (m1_req && winner != 3 && m_blk1 < CMAX) m_blk1++;
      end

      m_we = '0;
      case (winner)
        1: begin
          m_addr = disp_addr;
          sl_src[due] = 1; sl_dat[due] = mem_m[disp_addr];
        end
        2: begin
          m_addr = m0_addr; m_we = m0_we; m_din = m0_wdata; m_last_m1 = 1'b0;
          if (m0_we == 4'b0) begin sl_src[due] = 2; sl_dat[due] = mem_m[m0_addr]; end
          else mem_m[m0_addr] = merge(mem_m[m0_addr], m0_wdata, m0_we);
        end
        3: begin
          m_addr = m1_addr; m_we = m1_we; m_din = m1_wdata; m_last_m1 = 1'b1;
          if (m1_we == 4'b0) begin sl_src[due] = 3; sl_dat[due] = mem_m[m1_addr]; end
          else mem_m[m1_addr] = merge(mem_m[m1_addr], m1_wdata, m1_we);
        end
        default: ;
      endcase
    end
    cyc++;
  end

  // Capture display returns during the stream test
  bit cap_en = 1'b0;
  logic [31:0] cap_q [$];
  always @(negedge clk_pix) begin
    if (cap_en && !rst_pix && disp_valid) cap_q.push_back(disp_data);
  end

  task automatic step();
    @(posedge clk_pix);
    #1;
  endtask

  initial begin
    rst_pix = 1; frame_start = 0; disp_read = 0; disp_addr = '0;
    m0_req = 0; m0_we = '0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = '0; m1_addr = '0; m1_wdata = '0;
    repeat (3) step();
    rst_pix = 0;
    @(negedge clk_pix);
    chk("reset_vram_we", vram_we, 0);
    chk("reset_vram_addr", vram_addr, 0);
    chk("reset_vram_din", vram_din, 0);
    chk("reset_m0_blk", m0_blk_cnt, 0);
    step();

    // display stream 0x10..0x17
    cap_en = 1;
    for (int i = 0; i < 8; i++) begin
      disp_read = 1; disp_addr = 14'h10 + 14'(i);
      step();
    end
    disp_read = 0;
    repeat (4) step();
    cap_en = 0;
    chk("stream_count", cap_q.size(), 8);
    if (cap_q.size() == 8) begin
      chk("stream_first", cap_q[0], 32'hA500_0010);
      chk("stream_last", cap_q[7], 32'hA500_0017);
    end

    // m0/m1 contention, m0 first after reset
    m0_req = 1; m1_req = 1; m0_addr = 14'h40; m1_addr = 14'h41;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_pix);
      chk("rr_m0_ack", m0_ack, (k % 2) == 0);
      chk("rr_m1_ack", m1_ack, (k % 2) == 1);
      step();
    end
    m0_req = 0; m1_req = 0;
    repeat (3) step();

    // display priority over m0
    frame_start = 1; step(); frame_start = 0;
    disp_read = 1; disp_addr = 14'h11; m0_req = 1; m0_addr = 14'h20;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_pix);
      chk("prio_m0_held", m0_ack, 0);
      step();
    end
    disp_read = 0;
    @(negedge clk_pix);
    chk("prio_m0_ack", m0_ack, 1);
    chk("prio_blk5", m0_blk_cnt, 5);
    step();
    m0_req = 0;
    step();
    @(negedge clk_pix);
    chk("prio_rvalid", m0_rvalid, 1);
    chk("prio_rdata", m0_rdata, 32'hA500_0020);
    step();
    frame_start = 1; step(); frame_start = 0;
    @(negedge clk_pix);
    chk("frame_clear", m0_blk_cnt, 0);
    step();

    // m1 byte write then m0 read back
    m1_req = 1; m1_we = 4'b0011; m1_addr = 14'h30; m1_wdata = 32'hAABB_CCDD;
    @(negedge clk_pix);
    chk("wr_m1_ack", m1_ack, 1);
    step();
    m1_req = 0; m1_we = '0; m0_req = 1; m0_addr = 14'h30;
    @(negedge clk_pix);
    chk("wr_m0_ack", m0_ack, 1);
    chk("wr_vram_we", vram_we, 4'b0011);
    step();
    m0_req = 0;
    step();
    @(negedge clk_pix);
    chk("wr_rvalid", m0_rvalid, 1);
    chk("wr_rdata", m0_rdata, 32'hA500_CCDD);
    step();

    // reset with a read in flight
    m0_req = 1; m0_addr = 14'h40;
    @(negedge clk_pix);
    chk("rst_m0_ack", m0_ack, 1);
    step();
    m0_req = 0; rst_pix = 1;
    step();
    rst_pix = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_pix);
      chk("rst_no_rvalid", m0_rvalid, 0);
      chk("rst_vram_addr", vram_addr, 0);
      step();
    end
    m0_req = 1; m1_req = 1; m0_addr = 14'h50; m1_addr = 14'h51;
    @(negedge clk_pix);
    chk("rst_rr_m0", m0_ack, 1);
    chk("rst_rr_m1", m1_ack, 0);
    step();
    m0_req = 0;
    @(negedge clk_pix);
    chk("rst_then_m1", m1_ack, 1);
    step();
    m1_req = 0;
    step();

    // saturation of m1 refusal counter
    frame_start = 1; step(); frame_start = 0;
    disp_read = 1; disp_addr = 14'h12; m1_req = 1; m1_addr = 14'h60;
    repeat (20) step();
    @(negedge clk_pix);
    chk("sat_blk15", m1_blk_cnt, 15);
    chk("sat_m1_held", m1_ack, 0);
    step();
    disp_read = 0;
    @(negedge clk_pix);
    chk("sat_m1_ack", m1_ack, 1);
    step();
    m1_req = 0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
